// File: rtl/fetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue_if                                                        |
// | Decode-side and instruction-memory-side signals of the fetch queue.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface fetch_queue_if;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pcplus4;

   // master is the fetch queue itself; slave is its surroundings.
   modport master (
      input  redirect, redirect_pc, stall, imem_ack, imem_rdata,
      output imem_req, imem_addr, instr_valid, instr, pcplus4
   );

   modport slave (
      output redirect, redirect_pc, stall, imem_ack, imem_rdata,
      input  imem_req, imem_addr, instr_valid, instr, pcplus4
   );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue                                                           |
// | Instruction fetch front end: req/ack memory fetch into a small FIFO.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  wire logic       clk,
   input  wire logic       reset,
   fetch_queue_if.master   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t          state_q,    state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   count_q,    count_d;
   logic [PW-1:0]   head_q,     head_d;
   logic [PW-1:0]   tail_q,     tail_d;
   logic            imem_req_q, imem_req_d;
   logic [31:0]     instr_mem_q [DEPTH];
   logic [31:0]     instr_mem_d [DEPTH];
   logic [31:0]     pc4_mem_q   [DEPTH];
   logic [31:0]     pc4_mem_d   [DEPTH];

   logic            pop;
   logic            push;
   logic            space;
   logic [31:0]     redirect_target;
   logic            unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
   assign redirect_target      = {bus.redirect_pc[31:2], 2'b00};

   assign pop  = (count_q != '0) && !bus.stall && !bus.redirect;
   assign push = (state_q == REQ) && bus.imem_ack && !bus.redirect;

   always_comb begin
      count_d     = count_q;
      head_d      = head_q;
      tail_d      = tail_q;
      fetch_pc_d  = fetch_pc_q;
      instr_mem_d = instr_mem_q;
      pc4_mem_d   = pc4_mem_q;

      if (bus.redirect) begin
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         fetch_pc_d = redirect_target;
      end else begin
         count_d = count_q + CW'(push) - CW'(pop);
         if (pop) begin
            head_d = head_q + PW'(1);
         end
         if (push) begin
            instr_mem_d[tail_q] = bus.imem_rdata;
            pc4_mem_d[tail_q]   = fetch_pc_q + 32'd4;
            tail_d              = tail_q + PW'(1);
            fetch_pc_d          = fetch_pc_q + 32'd4;
         end
      end
   end

   // A new request is only issued when its response is guaranteed a slot.
   assign space = (count_d < CW'(DEPTH));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.redirect || space) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.imem_ack) begin
               state_d = (bus.redirect || space) ? REQ : IDLE;
            end else if (bus.redirect) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (bus.redirect) begin
               state_d = DROP;
            end else if (bus.imem_ack) begin
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
      imem_req_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         imem_req_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            pc4_mem_q[i]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         count_q     <= count_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         imem_req_q  <= imem_req_d;
         instr_mem_q <= instr_mem_d;
         pc4_mem_q   <= pc4_mem_d;
      end
   end

   assign bus.imem_req    = imem_req_q;
   assign bus.imem_addr   = fetch_pc_q;
   assign bus.instr_valid = (count_q != '0);
   assign bus.instr       = instr_mem_q[head_q];
   assign bus.pcplus4     = pc4_mem_q[head_q];

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_queue                                                        |
// | Directed bench; memory returns addr ^ 32'hA5A50000 after wait_n cycles|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_fetch_queue;
   logic clk;
   logic reset;
   int   wait_n;
   int   wcnt;
   int   n_ack;
   int   n_cmp;
   int   n_err;

   fetch_queue_if bus ();

   fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bus.imem_ack   = bus.imem_req && (wcnt == wait_n);
   assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         wcnt  <= 0;
         n_ack <= 0;
      end else begin
         wcnt <= (!bus.imem_req || bus.imem_ack) ? 0 : wcnt + 1;
         if (bus.imem_req && bus.imem_ack && !bus.redirect) begin
            n_ack <= n_ack + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      wait_n          = 0;
      reset           = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      wait_n          = 0;
      step();
      check("rst_req",   {31'd0, bus.imem_req},    32'd0);
      check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("rst_instr", bus.instr,                32'h0);
      check("rst_pc4",   bus.pcplus4,              32'h0);
      check("rst_addr",  bus.imem_addr,            32'h0);

      // zero-wait streaming
      reset = 1'b1;
      step();
      check("zw_c1_req",   {31'd0, bus.imem_req},    32'd1);
      check("zw_c1_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("zw_c1_addr",  bus.imem_addr,            32'h0);
      step();
      check("zw_c2_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("zw_c2_instr", bus.instr,                32'hA5A5_0000);
      check("zw_c2_pc4",   bus.pcplus4,              32'h4);
      check("zw_c2_addr",  bus.imem_addr,            32'h4);
      step();
      check("zw_c3_instr", bus.instr,                32'hA5A5_0004);
      check("zw_c3_pc4",   bus.pcplus4,              32'h8);
      check("zw_c3_addr",  bus.imem_addr,            32'h8);
      step();
      check("zw_c4_instr", bus.instr,                32'hA5A5_0008);
      check("zw_c4_pc4",   bus.pcplus4,              32'hC);

      // stall until full, then release
      do_reset();
      bus.stall = 1'b1;
      repeat (7) step();
      check("full_req",   {31'd0, bus.imem_req}, 32'd0);
      check("full_acks",  n_ack,                 32'd4);
      check("full_instr", bus.instr,             32'hA5A5_0000);
      check("full_pc4",   bus.pcplus4,           32'h4);
      check("full_addr",  bus.imem_addr,         32'h10);
      bus.stall = 1'b0;
      step();
      check("rel_instr1", bus.instr,             32'hA5A5_0004);
      check("rel_pc4_1",  bus.pcplus4,           32'h8);
      check("rel_req",    {31'd0, bus.imem_req}, 32'd1);
      step();
      check("rel_instr2", bus.instr,             32'hA5A5_0008);
      step();
      check("rel_instr3", bus.instr,             32'hA5A5_000C);
      step();
      check("rel_instr4", bus.instr,             32'hA5A5_0010);
      check("rel_pc4_4",  bus.pcplus4,           32'h14);

      // redirect during wait: DROP path
      do_reset();
      wait_n = 3;
      step();
      check("drop_c1_addr", bus.imem_addr, 32'h0);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h100;
      step();
      bus.redirect = 1'b0;
      check("drop_req",  {31'd0, bus.imem_req}, 32'd1);
      check("drop_addr", bus.imem_addr,         32'h100);
      for (int i = 0; i < 7; i++) begin
         check("drop_valid", {31'd0, bus.instr_valid}, 32'd0);
         check("drop_addr_hold", bus.imem_addr, 32'h100);
         if (i < 6) step();
      end
      step();
      check("drop_dl_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("drop_dl_instr", bus.instr,                32'hA5A5_0100);
      check("drop_dl_pc4",   bus.pcplus4,              32'h104);

      // redirect coincident with ack, queue non-empty
      do_reset();
      bus.stall = 1'b1;
      repeat (3) step();
      check("ra_pre_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("ra_pre_instr", bus.instr,                32'hA5A5_0000);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h40;
      step();
      bus.redirect = 1'b0;
      bus.stall    = 1'b0;
      check("ra_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("ra_addr",  bus.imem_addr,            32'h40);
      check("ra_req",   {31'd0, bus.imem_req},    32'd1);
      step();
      check("ra_instr", bus.instr,   32'hA5A5_0040);
      check("ra_pc4",   bus.pcplus4, 32'h44);

      // asynchronous reset mid-request with two entries queued
      do_reset();
      bus.stall = 1'b1;
      repeat (3) step();
      check("ar_pre_valid", {31'd0, bus.instr_valid}, 32'd1);
      reset = 1'b0;
      #1;
      check("ar_req",   {31'd0, bus.imem_req},    32'd0);
      check("ar_valid", {31'd0, bus.instr_valid}, 32'd0);
      check("ar_instr", bus.instr,                32'h0);
      check("ar_pc4",   bus.pcplus4,              32'h0);
      check("ar_addr",  bus.imem_addr,            32'h0);
      step();
      bus.stall = 1'b0;
      reset     = 1'b1;
      step();
      check("ar_rs_req",  {31'd0, bus.imem_req}, 32'd1);
      check("ar_rs_addr", bus.imem_addr,         32'h0);
      step();
      check("ar_rs_instr", bus.instr, 32'hA5A5_0000);

      // wrap at top of address space; low target bits ignored
      do_reset();
      step();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'hFFFF_FFFF;
      step();
      bus.redirect = 1'b0;
      bus.stall    = 1'b1;
      check("wrap_addr",  bus.imem_addr,            32'hFFFF_FFFC);
      check("wrap_valid", {31'd0, bus.instr_valid}, 32'd0);
      step();
      check("wrap_dl_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("wrap_dl_instr", bus.instr,                32'h5A5A_FFFC);
      check("wrap_dl_pc4",   bus.pcplus4,              32'h0);
      check("wrap_next_addr", bus.imem_addr,           32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
